// File: rtl/idli_pred_ctl_m.sv
// idli predicate controller: guard sampling, serial
// 16-bit compare and predicate write-back sequencing.
module idli_pred_ctl_m (
  input  logic       i_pctl_gck,
  input  logic       i_pctl_rst,
  input  logic       i_pctl_start,
  input  logic [2:0] i_pctl_op,
  input  logic [1:0] i_pctl_p,
  input  logic [1:0] i_pctl_q,
  input  logic       i_pctl_a,
  input  logic       i_pctl_b,
  output logic [1:0] o_pctl_prf_p,
  input  logic       i_pctl_prf_p_data,
  output logic [1:0] o_pctl_prf_q,
  input  logic       i_pctl_prf_q_data,
  output logic       o_pctl_prf_q_wr_en,
  output logic       o_pctl_prf_q_data,
  output logic       o_pctl_exec,
  output logic       o_pctl_busy,
  output logic       o_pctl_done
);

  typedef logic [1:0] preg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WB
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_EQ   = 3'b001;
  localparam logic [2:0] OP_NE   = 3'b010;
  localparam logic [2:0] OP_LTU  = 3'b011;
  localparam logic [2:0] OP_LTS  = 3'b100;
  localparam logic [2:0] OP_GEU  = 3'b101;
  localparam logic [2:0] OP_GES  = 3'b110;
  localparam logic [2:0] OP_INV  = 3'b111;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [2:0] op_q;
  preg_t      p_q;
  preg_t      q_q;
  logic       eq_q;
  logic       ltu_q;
  logic       res_q;
  logic       exec_q;

  logic accept;
  logic is_cmp;
  logic in_run;
  logic in_wb;
  logic last_bit;
  logic bit_eq;
  logic eq_n;
  logic ltu_n;
  logic lts_n;
  logic cmp_res;
  logic wr_en;
  logic wr_data;
  logic exec_d;

  // Next state, serial compare datapath and WB outputs.
  always_comb begin
    state_d  = state_q;
    in_run   = (state_q == S_RUN);
    in_wb    = (state_q == S_WB);
    accept   = i_pctl_start & ~in_run;
    is_cmp   = (i_pctl_op != OP_NONE) &&
               (i_pctl_op != OP_INV);
    last_bit = (cnt_q == 4'd15);

    bit_eq = ~(i_pctl_a ^ i_pctl_b);
    eq_n   = eq_q & bit_eq;
    ltu_n  = (~i_pctl_a & i_pctl_b) |
             (bit_eq & ltu_q);
    lts_n  = (i_pctl_a & ~i_pctl_b) |
             (bit_eq & ltu_q);

    cmp_res = 1'b0;
    unique case (op_q)
      OP_EQ:   cmp_res = eq_n;
      OP_NE:   cmp_res = ~eq_n;
      OP_LTU:  cmp_res = ltu_n;
      OP_GEU:  cmp_res = ~ltu_n;
      OP_LTS:  cmp_res = lts_n;
      OP_GES:  cmp_res = ~lts_n;
      default: cmp_res = 1'b0;
    endcase

    wr_data = (op_q == OP_INV) ?
              ~i_pctl_prf_q_data : res_q;
    wr_en   = in_wb & exec_q &
              (op_q != OP_NONE);

    // Forward a same-cycle WB write to the
    // guard read of a back-to-back start.
    if (i_pctl_p == 2'd3)
      exec_d = 1'b1;
    else if (wr_en && (i_pctl_p == q_q))
      exec_d = wr_data;
    else
      exec_d = i_pctl_prf_p_data;

    unique case (1'b1)
      in_run: begin
        if (last_bit)
          state_d = S_WB;
      end
      default: begin
        if (accept)
          state_d = is_cmp ? S_RUN : S_WB;
        else
          state_d = S_IDLE;
      end
    endcase

    o_pctl_prf_p       = in_run ? p_q : i_pctl_p;
    o_pctl_prf_q       = q_q;
    o_pctl_prf_q_wr_en = wr_en;
    o_pctl_prf_q_data  = in_wb & wr_data;
    o_pctl_exec        = exec_q;
    o_pctl_busy        = in_run;
    o_pctl_done        = in_wb;
  end

  // State register, latched instruction fields
  // and accumulated compare state.
  always_ff @(posedge i_pctl_gck) begin
    if (i_pctl_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_NONE;
      p_q     <= 2'd0;
      q_q     <= 2'd0;
      eq_q    <= 1'b1;
      ltu_q   <= 1'b0;
      res_q   <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= i_pctl_op;
        p_q    <= i_pctl_p;
        q_q    <= i_pctl_q;
        eq_q   <= 1'b1;
        ltu_q  <= 1'b0;
        cnt_q  <= 4'd0;
        exec_q <= exec_d;
      end else if (in_run) begin
        cnt_q <= cnt_q + 4'd1;
        eq_q  <= eq_n;
        ltu_q <= ltu_n;
        if (last_bit)
          res_q <= cmp_res;
      end
    end
  end

endmodule

// File: tb/tb_idli_pred_ctl_m.sv
// Self-checking bench for idli_pred_ctl_m with a
// behavioural PRF and arithmetic reference model.
module tb_idli_pred_ctl_m;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_i;
  logic [1:0] p_i;
  logic [1:0] q_i;
  logic       a_i;
  logic       b_i;
  logic [1:0] prf_p;
  logic       p_data;
  logic [1:0] prf_q;
  logic       q_data;
  logic       wr_en;
  logic       wdata;
  logic       exec;
  logic       busy;
  logic       done;

  logic prf [4];
  logic mp  [4];
  logic wr_clr;
  int   wr_cnt;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  idli_pred_ctl_m dut (
    .i_pctl_gck         (clk),
    .i_pctl_rst         (rst),
    .i_pctl_start       (start),
    .i_pctl_op          (op_i),
    .i_pctl_p           (p_i),
    .i_pctl_q           (q_i),
    .i_pctl_a           (a_i),
    .i_pctl_b           (b_i),
    .o_pctl_prf_p       (prf_p),
    .i_pctl_prf_p_data  (p_data),
    .o_pctl_prf_q       (prf_q),
    .i_pctl_prf_q_data  (q_data),
    .o_pctl_prf_q_wr_en (wr_en),
    .o_pctl_prf_q_data  (wdata),
    .o_pctl_exec        (exec),
    .o_pctl_busy        (busy),
    .o_pctl_done        (done)
  );

  assign p_data = (prf_p == 2'd3) ? 1'b1 : prf[prf_p];
  assign q_data = (prf_q == 2'd3) ? 1'b1 : prf[prf_q];

  // Predicate register file; P3 is hard-wired one.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) prf[i] <= 1'b0;
    end else if (wr_en && prf_q != 2'd3) begin
      prf[prf_q] <= wdata;
    end
  end

  // Counts write strobes for the reset scenario.
  always @(posedge clk) begin
    if (wr_clr) wr_cnt <= 0;
    else if (wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic ref_res(
      input logic [2:0] op, input logic [1:0] q,
      input logic [15:0] a, input logic [15:0] b);
    logic qv;
    qv = (q == 2'd3) ? 1'b1 : mp[q];
    case (op)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return a < b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return a >= b;
      3'd6: return $signed(a) >= $signed(b);
      3'd7: return ~qv;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge in IDLE or WB; returns at the
  // negedge of this instruction's WB cycle.
  task automatic issue(input logic [2:0] op,
                       input logic [1:0] p,
                       input logic [1:0] q,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input int poke);
    logic ex, cmp, res, ew;
    ex  = (p == 2'd3) ? 1'b1 : mp[p];
    cmp = (op != 3'd0) && (op != 3'd7);
    start = 1'b1; op_i = op; p_i = p; q_i = q;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("exec_t1", exec, ex);
    check("busy_t1", busy, cmp);
    if (cmp) begin
      for (int k = 0; k < 16; k++) begin
        a_i = a[k]; b_i = b[k];
        check("busy_run", busy, 1'b1);
        if (k == poke) begin
          start = 1'b1; op_i = 3'd7;
          q_i = ~q; p_i = 2'd3;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); @(negedge clk);
      end
      start = 1'b0;
      check("q_hold", prf_q, q);
    end
    res = ref_res(op, q, a, b);
    ew  = ex && (op != 3'd0);
    check("done_wb", done, 1'b1);
    check("busy_wb", busy, 1'b0);
    check("exec_wb", exec, ex);
    check("wr_en_wb", wr_en, ew);
    if (op != 3'd0) check("data_wb", wdata, res);
    if (ew && q != 2'd3) mp[q] = res;
  endtask

  task automatic gap();
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("done_idle", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("wr_idle", wr_en, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_i = 3'd0;
    p_i = 2'd2; q_i = 2'd1; a_i = 1'b0; b_i = 1'b0;
    wr_clr = 1'b1;
    for (int i = 0; i < 3; i++) mp[i] = 1'b0;
    mp[3] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_exec", exec, 1'b0);
    check("rst_wr", wr_en, 1'b0);
    check("rst_wdata", wdata, 1'b0);
    check("rst_prf_q", prf_q, 2'd0);
    check("rst_prf_p", prf_p, 2'd2);
    rst = 1'b0;

    issue(3'd1, 2'd3, 2'd0, 16'h1234, 16'h1234, -1);
    gap();
    issue(3'd1, 2'd3, 2'd0, 16'h1234, 16'h1235, -1);
    gap();
    issue(3'd4, 2'd3, 2'd1, 16'h8000, 16'h0001, -1);
    issue(3'd3, 2'd3, 2'd1, 16'h8000, 16'h0001, -1);
    gap();
    check("p1_after_ltu", prf[1], 1'b0);

    issue(3'd1, 2'd0, 2'd2, 16'h5a5a, 16'h5a5a, -1);
    gap();
    check("p2_unchanged", prf[2], 1'b0);
    issue(3'd6, 2'd3, 2'd2, 16'hffff, 16'hffff, -1);
    gap();
    check("p2_ges", prf[2], 1'b1);

    issue(3'd7, 2'd3, 2'd1, 16'h0, 16'h0, -1);
    issue(3'd7, 2'd1, 2'd1, 16'h0, 16'h0, -1);
    gap();
    check("p1_inv2", prf[1], 1'b0);

    issue(3'd1, 2'd3, 2'd2, 16'h00f0, 16'h00f0, 5);
    gap();

    wr_clr = 1'b0;
    start = 1'b1; op_i = 3'd3; p_i = 2'd3; q_i = 2'd1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      a_i = 1'b0; b_i = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstrun_busy", busy, 1'b0);
    check("rstrun_exec", exec, 1'b0);
    check("rstrun_done", done, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mp[i] = 1'b0;
    issue(3'd0, 2'd3, 2'd2, 16'h0, 16'h0, -1);
    gap();
    check("rstrun_nowr", wr_cnt, 0);
    wr_clr = 1'b1;

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      issue(3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ra, rb, -1);
      if ($urandom_range(0, 1) == 1) gap();
    end
    gap();
    for (int i = 0; i < 3; i++)
      check("prf_final", prf[i], mp[i]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
